// File: rtl/elevator_bank_dispatcher.sv
// Elevator bank dispatcher.
// Runs one IDLE/MOVE/DOOR motion FSM per car over a shared, latched stop table.
// Each shared hall call is handed to the cheapest car. Positions count in half-floors,
// so an even value is a floor and an odd value is between two floors.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   simState           0=START 1=SIM 2=PAUSE 3=ENDING
//   carRequests        in-car stop requests, car c at [c*NUM_FLOORS +: NUM_FLOORS]
//   hallRequests       shared hall calls, one bit per floor
//   half_carPositions  car c half-floor position at [c*POS_W +: POS_W]
//   directions         1=up 0=down per car
//   doorsOpen          1 while a car is in DOOR
//   pendingStops       latched stop table, same packing as carRequests
module elevator_bank_dispatcher #(
    parameter int unsigned NUM_CARS   = 2,
    parameter int unsigned NUM_FLOORS = 6,
    parameter int unsigned MOVE_TICKS = 4,
    parameter int unsigned DOOR_TICKS = 8,
    parameter int unsigned POS_W      = $clog2(2 * NUM_FLOORS - 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     simState,
    input  logic [NUM_CARS*NUM_FLOORS-1:0] carRequests,
    input  logic [NUM_FLOORS-1:0]          hallRequests,
    output logic [NUM_CARS*POS_W-1:0]      half_carPositions,
    output logic [NUM_CARS-1:0]            directions,
    output logic [NUM_CARS-1:0]            doorsOpen,
    output logic [NUM_CARS*NUM_FLOORS-1:0] pendingStops
);

    localparam int unsigned TmrMax = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [POS_W-1:0] TopPos = POS_W'(2 * (NUM_FLOORS - 1));

    typedef enum logic [1:0] {StIdle, StMove, StDoor} car_state_e;

    car_state_e                     st_q   [NUM_CARS];
    logic [POS_W-1:0]               pos_q  [NUM_CARS];
    logic [TmrW-1:0]                tmr_q  [NUM_CARS];
    logic [NUM_CARS-1:0]            dir_q;
    logic [NUM_CARS*NUM_FLOORS-1:0] pend_q, pend_d;

    logic [POS_W-1:0]               new_pos [NUM_CARS];
    logic [NUM_CARS-1:0]            here, up_any, dn_any, hit_new, ahead_new;
    logic [NUM_CARS*NUM_FLOORS-1:0] hall_set, clr;
    logic                           en, latch;

    assign en    = (simState == 2'd1);
    assign latch = (simState == 2'd1) || (simState == 2'd2);

    // Per-car stop lookups relative to the current and the next half-floor position.
    always_comb begin
        clr = '0;
        for (int c = 0; c < NUM_CARS; c++) begin
            here[c]      = 1'b0;
            up_any[c]    = 1'b0;
            dn_any[c]    = 1'b0;
            hit_new[c]   = 1'b0;
            ahead_new[c] = 1'b0;
            new_pos[c]   = dir_q[c] ? pos_q[c] + 1'b1 : pos_q[c] - 1'b1;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (pend_q[c*NUM_FLOORS + f]) begin
                    if (pos_q[c] == POS_W'(2 * f)) here[c] = 1'b1;
                    if (POS_W'(2 * f) > pos_q[c]) up_any[c] = 1'b1;
                    if (POS_W'(2 * f) < pos_q[c]) dn_any[c] = 1'b1;
                    if (new_pos[c] == POS_W'(2 * f)) hit_new[c] = 1'b1;
                    if (dir_q[c] ? (POS_W'(2 * f) > new_pos[c]) : (POS_W'(2 * f) < new_pos[c]))
                        ahead_new[c] = 1'b1;
                end
            end
            // Stops served now: the floor a car opens at (or stands open at), and the floor
            // it arrives at when a step lands on a pending stop.
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (en && pos_q[c] == POS_W'(2 * f) &&
                    ((st_q[c] == StIdle && here[c]) || st_q[c] == StDoor))
                    clr[c*NUM_FLOORS + f] = 1'b1;
                if (en && st_q[c] == StMove && tmr_q[c] == '0 && hit_new[c] &&
                    new_pos[c] == POS_W'(2 * f))
                    clr[c*NUM_FLOORS + f] = 1'b1;
            end
        end
    end

    // Hall arbitration: every floor is arbitrated independently; ties go to the lowest index.
    always_comb begin
        int   p, d, best, best_cost;
        logic taken;
        hall_set  = '0;
        p         = 0;
        d         = 0;
        best      = 0;
        best_cost = 0;
        taken     = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            taken     = 1'b0;
            best      = 0;
            best_cost = 0;
            for (int c = 0; c < NUM_CARS; c++) begin
                taken = taken | pend_q[c*NUM_FLOORS + f] | carRequests[c*NUM_FLOORS + f];
                p = int'(pos_q[c]);
                d = p - 2 * f;
                if (d < 0) d = -d;
                // A moving car heading away from the call pays a large penalty.
                if (st_q[c] == StMove && (dir_q[c] ? (2 * f < p) : (2 * f > p)))
                    d = d + int'(4 * NUM_FLOORS);
                if (c == 0 || d < best_cost) begin
                    best_cost = d;
                    best      = c;
                end
            end
            for (int c = 0; c < NUM_CARS; c++) begin
                if (hallRequests[f] && !taken && c == best)
                    hall_set[c*NUM_FLOORS + f] = 1'b1;
            end
        end
    end

    always_comb begin
        if (simState == 2'd0) pend_d = '0;
        else if (latch)       pend_d = (pend_q | carRequests | hall_set) & ~clr;
        else                  pend_d = pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            dir_q  <= '1;
            for (int c = 0; c < NUM_CARS; c++) begin
                st_q[c]  <= StIdle;
                pos_q[c] <= '0;
                tmr_q[c] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            if (en) begin
                for (int c = 0; c < NUM_CARS; c++) begin
                    case (st_q[c])
                        StIdle: begin
                            if (here[c]) begin
                                st_q[c]  <= StDoor;
                                tmr_q[c] <= TmrW'(DOOR_TICKS - 1);
                                if (pos_q[c] == TopPos)  dir_q[c] <= 1'b0;
                                else if (pos_q[c] == '0) dir_q[c] <= 1'b1;
                            end else if (dir_q[c] ? up_any[c] : dn_any[c]) begin
                                st_q[c]  <= StMove;
                                tmr_q[c] <= TmrW'(MOVE_TICKS - 1);
                            end else if (dir_q[c] ? dn_any[c] : up_any[c]) begin
                                st_q[c]  <= StMove;
                                dir_q[c] <= ~dir_q[c];
                                tmr_q[c] <= TmrW'(MOVE_TICKS - 1);
                            end
                        end
                        StMove: begin
                            if (tmr_q[c] == '0) begin
                                pos_q[c] <= new_pos[c];
                                tmr_q[c] <= TmrW'(MOVE_TICKS - 1);
                                if (hit_new[c]) begin
                                    st_q[c]  <= StDoor;
                                    tmr_q[c] <= TmrW'(DOOR_TICKS - 1);
                                end else if (!new_pos[c][0] && !ahead_new[c]) begin
                                    st_q[c] <= StIdle;
                                end
                            end else begin
                                tmr_q[c] <= tmr_q[c] - 1'b1;
                            end
                        end
                        StDoor: begin
                            if (tmr_q[c] == '0) st_q[c] <= StIdle;
                            else                tmr_q[c] <= tmr_q[c] - 1'b1;
                        end
                        default: st_q[c] <= StIdle;
                    endcase
                end
            end
        end
    end

    always_comb begin
        half_carPositions = '0;
        doorsOpen         = '0;
        for (int c = 0; c < NUM_CARS; c++) begin
            half_carPositions[c*POS_W +: POS_W] = pos_q[c];
            doorsOpen[c]                        = (st_q[c] == StDoor);
        end
    end

    assign directions   = dir_q;
    assign pendingStops = pend_q;

endmodule

// File: tb/tb_elevator_bank_dispatcher.sv
// Directed bench for elevator_bank_dispatcher (2 cars, 6 floors, 4 move ticks, 8 door ticks).
module tb_elevator_bank_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  simState;
    logic [11:0] carRequests;
    logic [5:0]  hallRequests;
    logic [7:0]  half_carPositions;
    logic [1:0]  directions;
    logic [1:0]  doorsOpen;
    logic [11:0] pendingStops;

    int tests_run    = 0;
    int tests_failed = 0;

    elevator_bank_dispatcher #(
        .NUM_CARS  (2),
        .NUM_FLOORS(6),
        .MOVE_TICKS(4),
        .DOOR_TICKS(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .simState         (simState),
        .carRequests      (carRequests),
        .hallRequests     (hallRequests),
        .half_carPositions(half_carPositions),
        .directions       (directions),
        .doorsOpen        (doorsOpen),
        .pendingStops     (pendingStops)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] pos_of(input int c);
        return half_carPositions[c*4 +: 4];
    endfunction

    task automatic test_reset();
        rst = 1'b1; simState = 2'd1; carRequests = '0; hallRequests = '0;
        repeat (2) tick();
        rst = 1'b0;
        tests_run++;
        if (half_carPositions !== 8'h00) begin
            tests_failed++; $display("FAIL reset_pos got %h want 00", half_carPositions);
        end
        tests_run++;
        if (directions !== 2'b11) begin
            tests_failed++; $display("FAIL reset_dir got %b want 11", directions);
        end
        tests_run++;
        if (doorsOpen !== 2'b00 || pendingStops !== 12'h000) begin
            tests_failed++; $display("FAIL reset_door_pend got %b/%h want 00/000", doorsOpen, pendingStops);
        end
        // Get car0 moving, then reset mid-motion.
        carRequests = 12'h008;
        tick();
        carRequests = '0;
        repeat (10) tick();
        tests_run++;
        if (pos_of(0) !== 4'd2) begin
            tests_failed++; $display("FAIL premotion_pos got %0d want 2", pos_of(0));
        end
        do_reset();
        tests_run++;
        if (half_carPositions !== 8'h00 || directions !== 2'b11 || doorsOpen !== 2'b00 ||
            pendingStops !== 12'h000) begin
            tests_failed++;
            $display("FAIL midreset got pos=%h dir=%b door=%b pend=%h want 00/11/00/000",
                     half_carPositions, directions, doorsOpen, pendingStops);
        end
    endtask

    task automatic test_door_open();
        int cnt;
        carRequests = 12'h001;
        tick();
        carRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h001 || doorsOpen !== 2'b00) begin
            tests_failed++; $display("FAIL door_latch got pend=%h door=%b want 001/00", pendingStops, doorsOpen);
        end
        tick();
        tests_run++;
        if (doorsOpen !== 2'b01 || pendingStops !== 12'h000) begin
            tests_failed++; $display("FAIL door_open got door=%b pend=%h want 01/000", doorsOpen, pendingStops);
        end
        cnt = 1;
        for (int i = 0; i < 12; i++) begin
            carRequests = (i == 2) ? 12'h001 : 12'h000;  // same-floor request while open
            tick();
            if (doorsOpen[0]) cnt++;
        end
        carRequests = '0;
        tests_run++;
        if (cnt !== 8) begin
            tests_failed++; $display("FAIL door_length got %0d want 8", cnt);
        end
        tests_run++;
        if (doorsOpen !== 2'b00 || pendingStops !== 12'h000) begin
            tests_failed++; $display("FAIL door_close got door=%b pend=%h want 00/000", doorsOpen, pendingStops);
        end
    endtask

    task automatic test_move();
        logic bad;
        carRequests = 12'h004;
        tick();
        carRequests = '0;
        tick();
        for (int s = 1; s <= 4; s++) begin
            repeat (3) tick();
            tests_run++;
            if (pos_of(0) !== 4'(s - 1)) begin
                tests_failed++; $display("FAIL move_hold%0d got %0d want %0d", s, pos_of(0), s - 1);
            end
            tick();
            tests_run++;
            if (pos_of(0) !== 4'(s)) begin
                tests_failed++; $display("FAIL move_step%0d got %0d want %0d", s, pos_of(0), s);
            end
        end
        tests_run++;
        if (doorsOpen !== 2'b01 || pendingStops !== 12'h000) begin
            tests_failed++; $display("FAIL move_arrive got door=%b pend=%h want 01/000", doorsOpen, pendingStops);
        end
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (pos_of(0) !== 4'd4) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++; $display("FAIL move_overshoot got pos=%0d want 4", pos_of(0));
        end
        carRequests = 12'h001;
        tick();
        carRequests = '0;
        tick();
        tests_run++;
        if (directions !== 2'b10) begin
            tests_failed++; $display("FAIL reverse_dir got %b want 10", directions);
        end
        repeat (4) tick();
        tests_run++;
        if (pos_of(0) !== 4'd3) begin
            tests_failed++; $display("FAIL reverse_step got %0d want 3", pos_of(0));
        end
    endtask

    task automatic test_hall_assign();
        do_reset();
        carRequests = 12'h400;  // car1 to floor 4
        tick();
        carRequests = '0;
        repeat (41) tick();
        tests_run++;
        if (pos_of(1) !== 4'd8 || doorsOpen !== 2'b00) begin
            tests_failed++; $display("FAIL hall_setup1 got pos1=%0d door=%b want 8/00", pos_of(1), doorsOpen);
        end
        hallRequests = 6'b100000;
        tick();
        hallRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h800) begin
            tests_failed++; $display("FAIL hall_nearest got %h want 800", pendingStops);
        end
        do_reset();
        carRequests = 12'h100;  // car1 to floor 2
        tick();
        carRequests = '0;
        repeat (26) tick();
        tests_run++;
        if (pos_of(1) !== 4'd4 || pos_of(0) !== 4'd0) begin
            tests_failed++; $display("FAIL hall_setup2 got pos0=%0d pos1=%0d want 0/4", pos_of(0), pos_of(1));
        end
        hallRequests = 6'b000010;
        tick();
        hallRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h002) begin
            tests_failed++; $display("FAIL hall_tie got %h want 002", pendingStops);
        end
        do_reset();
        carRequests  = 12'h080;  // car1 floor 1 together with hall floor 1
        hallRequests = 6'b000010;
        tick();
        carRequests  = '0;
        hallRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h080) begin
            tests_failed++; $display("FAIL hall_dup got %h want 080", pendingStops);
        end
    endtask

    task automatic test_pause();
        logic bad;
        do_reset();
        carRequests = 12'h002;
        tick();
        carRequests = '0;
        repeat (3) tick();
        tests_run++;
        if (pos_of(0) !== 4'd0) begin
            tests_failed++; $display("FAIL pause_pre got %0d want 0", pos_of(0));
        end
        simState    = 2'd2;
        carRequests = 12'h008;
        tick();
        carRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h00A) begin
            tests_failed++; $display("FAIL pause_latch got %h want 00a", pendingStops);
        end
        bad = 1'b0;
        repeat (9) begin
            tick();
            if (pos_of(0) !== 4'd0) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++; $display("FAIL pause_frozen got pos=%0d want 0", pos_of(0));
        end
        simState = 2'd1;
        tick();
        tests_run++;
        if (pos_of(0) !== 4'd0) begin
            tests_failed++; $display("FAIL resume_wait got %0d want 0", pos_of(0));
        end
        tick();
        tests_run++;
        if (pos_of(0) !== 4'd1) begin
            tests_failed++; $display("FAIL resume_step got %0d want 1", pos_of(0));
        end
    endtask

    task automatic test_start_ending();
        simState    = 2'd2;
        carRequests = 12'h100;
        tick();
        carRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h10A) begin
            tests_failed++; $display("FAIL start_setup got %h want 10a", pendingStops);
        end
        simState = 2'd0;
        tick();
        tests_run++;
        if (pendingStops !== 12'h000 || pos_of(0) !== 4'd1) begin
            tests_failed++; $display("FAIL start_clear got pend=%h pos0=%0d want 000/1", pendingStops, pos_of(0));
        end
        tick();
        tests_run++;
        if (pos_of(0) !== 4'd1 || pos_of(1) !== 4'd0) begin
            tests_failed++; $display("FAIL start_hold got pos0=%0d pos1=%0d want 1/0", pos_of(0), pos_of(1));
        end
        simState     = 2'd3;
        carRequests  = '1;
        hallRequests = '1;
        repeat (3) tick();
        carRequests  = '0;
        hallRequests = '0;
        tests_run++;
        if (pendingStops !== 12'h000 || pos_of(0) !== 4'd1 || doorsOpen !== 2'b00) begin
            tests_failed++;
            $display("FAIL ending_ignore got pend=%h pos0=%0d door=%b want 000/1/00",
                     pendingStops, pos_of(0), doorsOpen);
        end
    endtask

    initial begin
        rst = 1'b1; simState = 2'd0; carRequests = '0; hallRequests = '0;
        test_reset();
        test_door_open();
        test_move();
        test_hall_assign();
        test_pause();
        test_start_ending();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
